fma_sequencer: RTL and testbench
================================

# fma_sequencer

Synchronous instruction sequencer sitting directly upstream of the BF16 FMA datapath. It walks the 50-bit instruction memory, registers each instruction word, and drives the A/B/C operands. It registers the FMA result into either the accumulator, which feeds back as C, or the display register, which feeds seg7_control. It replaces the free-running address counter and the level-sensitive result latches with a clocked FSM that has start/busy/done control and sticky exception flags.

## Interface
- ADDR_W, 4: instruction address width.
- LAST_ADDR, 15: address of the final instruction in a run.
- HOLD_CYCLES, 0: extra cycles spent after each instruction before the next fetch; 0 = no hold.
- clk_in  in  1: clock, rising edge.
- rst  in  1: reset, asynchronous, active-low.
- start  in  1: begin a run from address 0; sampled only in IDLE or DONE.
- instr_addr  out  ADDR_W: address to instruction memory.
- instr_data  in  50: [49] dest select (1 = acc, 0 = disp), [48] C select (1 = immediate, 0 = acc), [47:32] A, [31:16] B, [15:0] C immediate.
- A, B, C  out  16: FMA operands.
- fma_result  in  16: FMA result, combinational from A/B/C.
- fma_flags  in  7: {zero, underflow, overflow, qNaN, sNaN, positive_inf, negative_inf}.
- acc_out  out  16: accumulator register.
- disp_out  out  16: display register, to seg7_control.
- flags_out  out  7: fma_flags captured with the last result.
- exc_sticky  out  1: OR of underflow|overflow|qNaN|sNaN|pos_inf|neg_inf over the run.
- busy  out  1: high in FETCH/EXEC/HOLD.
- done  out  1: high in DONE.

## Operation
- States: IDLE, FETCH, EXEC, HOLD, DONE.
- IDLE:
  - start=1 → FETCH.
  - instr_addr ← 0; exc_sticky ← 0.
  - acc_out and disp_out are retained.
- FETCH: ir ← instr_data at instr_addr → EXEC.
- EXEC: A = ir[47:32]; B = ir[31:16]; C = ir[48] ? ir[15:0] : acc_out. At the clock edge leaving EXEC:
  - If ir[49]=1: acc_out ← fma_result. Otherwise disp_out ← fma_result.
  - flags_out ← fma_flags; exc_sticky |= exception bits.
  - If HOLD_CYCLES=0, go to the next-address step directly; otherwise → HOLD.
- HOLD: counts HOLD_CYCLES cycles, then the next-address step.
- Next-address step:
  - If instr_addr == LAST_ADDR → DONE.
  - Otherwise instr_addr ← instr_addr+1 → FETCH.
- DONE: holds all outputs. start=1 → FETCH with instr_addr ← 0 and exc_sticky ← 0.
- Outside EXEC, A/B/C still reflect ir and the current acc_out; this is don't-care for downstream.
- start while busy: ignored.
- LAST_ADDR = 2^ADDR_W−1: the address never wraps; the run ends in DONE.
- An EXEC with ir[49]=1 and ir[48]=0 reads the old acc_out and writes the new value at the same edge. No bypass is needed because FMA is combinational.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; instr_addr=0, ir=0, acc_out=0, disp_out=0, flags_out=0, exc_sticky=0, busy=0, done=0; A=B=C=0.
- Reset release: the first transition can occur on the first rising edge with rst=1.
- Per instruction: 2+HOLD_CYCLES cycles.
- Run of N=LAST_ADDR+1 instructions: start sampled at edge 0; done rises N·(2+HOLD_CYCLES) edges later.
- busy and done are registered (Moore) outputs.
- Reset mid-run: the run aborts immediately and all outputs return to their reset values.
- Result capture is a single edge at the end of EXEC. A/B/C are stable for the whole EXEC cycle.

## Test plan
- Reset: rst=0 during a run at state EXEC → all outputs 0 asynchronously, state IDLE; start after release restarts from addr 0.
- Immediate accumulate, HOLD_CYCLES=0:
  - Stimulus: word 0 = {1,1,0x3F80,0x4000,0x3F80}, LAST_ADDR=0.
  - Response: acc_out=0x4040 (1·2+1=3), disp_out=0, done 2 cycles after start.
- Feedback, LAST_ADDR=1:
  - Stimulus: word 0 as above; word 1 = {0,0,0x3F80,0x3F80,0x0000}.
  - Response: C=0x4040 during the second EXEC; disp_out=0x4080 (4.0); acc_out stays 0x4040.
- Hold and sequencing, HOLD_CYCLES=3, LAST_ADDR=3:
  - Response: instr_addr steps 0,1,2,3 every 5 cycles; done at cycle 20; second start while busy ignored.
- Exceptions:
  - Stimulus: word with A=0x7F80 (+inf), B=0x3F80, C=0x3F80.
  - Response: exc_sticky=1 and flags_out positive_inf=1.
  - exc_sticky persists through later normal instructions; cleared by the next start from DONE.
- Wrap boundary, ADDR_W=4, LAST_ADDR=15: after address 15 the FSM enters DONE; instr_addr never returns to 0 until start.

Source files
------------

// File: rtl/fma_sequencer.sv
// Clocked instruction sequencer feeding the BF16 FMA datapath.
// Fetches each word, drives A/B/C, and captures the result into acc or disp.
module fma_sequencer #(
    parameter int ADDR_W      = 4,
    parameter int LAST_ADDR   = 15,
    parameter int HOLD_CYCLES = 0
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [49:0]       instr_data,
    output logic [15:0]       A,
    output logic [15:0]       B,
    output logic [15:0]       C,
    input  logic [15:0]       fma_result,
    input  logic [6:0]        fma_flags,
    output logic [15:0]       acc_out,
    output logic [15:0]       disp_out,
    output logic [6:0]        flags_out,
    output logic              exc_sticky,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HOLD,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [49:0]       ir_q, ir_d;
    logic [15:0]       acc_q, acc_d;
    logic [15:0]       disp_q, disp_d;
    logic [6:0]        flags_q, flags_d;
    logic              exc_q, exc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              advance;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        disp_d  = disp_q;
        flags_d = flags_q;
        exc_d   = exc_q;
        cnt_d   = cnt_q;
        advance = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                addr_d = '0;
                exc_d  = 1'b0;
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = instr_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (ir_q[49]) acc_d = fma_result;
                else          disp_d = fma_result;
                flags_d = fma_flags;
                exc_d   = exc_q | (|fma_flags[5:0]);
                if (HOLD_CYCLES == 0) begin
                    advance = 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_MAX) advance = 1'b1;
                else                  cnt_d = cnt_q + 1'b1;
            end
            S_DONE: begin
                if (start) begin
                    addr_d  = '0;
                    exc_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The last address parks in DONE rather than wrapping to zero.
        if (advance) begin
            if (addr_q == LAST) begin
                state_d = S_DONE;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = S_FETCH;
            end
        end
        busy_d = (state_d == S_FETCH) || (state_d == S_EXEC) ||
                 (state_d == S_HOLD);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            disp_q  <= '0;
            flags_q <= '0;
            exc_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            disp_q  <= disp_d;
            flags_q <= flags_d;
            exc_q   <= exc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign instr_addr = addr_q;
    assign A          = ir_q[47:32];
    assign B          = ir_q[31:16];
    assign C          = ir_q[48] ? ir_q[15:0] : acc_q;
    assign acc_out    = acc_q;
    assign disp_out   = disp_q;
    assign flags_out  = flags_q;
    assign exc_sticky = exc_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fma_sequencer.sv
// Bench for fma_sequencer: four configurations driven by a stand-in FMA.
// A per-instruction reference model checks acc/disp/flags/sticky.
module tb_fma_sequencer;

    logic clk_in;
    logic rst;

    logic start0, start1, start2, start3;
    logic [3:0] addr0, addr1, addr2, addr3;
    logic [15:0] a0, b0, c0, res0, acc0, disp0;
    logic [15:0] a1, b1, c1, res1, acc1, disp1;
    logic [15:0] a2, b2, c2, res2, acc2, disp2;
    logic [15:0] a3, b3, c3, res3, acc3, disp3;
    logic [6:0] flg0, fo0, flg1, fo1, flg2, fo2, flg3, fo3;
    logic exc0, busy0, done0, exc1, busy1, done1;
    logic exc2, busy2, done2, exc3, busy3, done3;
    logic [49:0] mem0 [16];
    logic [49:0] mem1 [16];
    logic [49:0] mem2 [16];
    logic [49:0] mem3 [16];

    int tests;
    int fails;

    typedef struct {
        logic [49:0] word;
        logic        sticky;
    } vec_t;
    vec_t tbl [16];
    logic [49:0] prog [16];

    logic [15:0] m_acc, m_disp;
    logic [6:0]  m_flags;
    logic        m_exc;

    // Stand-in for the FMA: exact for the documented vectors, a mix otherwise.
    function automatic logic [15:0] fstub(logic [15:0] a, logic [15:0] b,
                                          logic [15:0] c);
        if (a == 16'h3F80 && b == 16'h4000 && c == 16'h3F80) return 16'h4040;
        if (a == 16'h3F80 && b == 16'h3F80 && c == 16'h4040) return 16'h4080;
        if (a == 16'h7F80) return 16'h7F80;
        return (a ^ {b[7:0], b[15:8]}) + c;
    endfunction

    function automatic logic [6:0] fflags(logic [15:0] a, logic [15:0] b,
                                          logic [15:0] c);
        logic [15:0] r;
        r = fstub(a, b, c);
        return {r == 16'h0, 4'b0, a == 16'h7F80, 1'b0};
    endfunction

    assign res0 = fstub(a0, b0, c0);
    assign flg0 = fflags(a0, b0, c0);
    assign res1 = fstub(a1, b1, c1);
    assign flg1 = fflags(a1, b1, c1);
    assign res2 = fstub(a2, b2, c2);
    assign flg2 = fflags(a2, b2, c2);
    assign res3 = fstub(a3, b3, c3);
    assign flg3 = fflags(a3, b3, c3);

    fma_sequencer #(.ADDR_W(4), .LAST_ADDR(0), .HOLD_CYCLES(0)) u0 (
        .clk_in(clk_in), .rst(rst), .start(start0),
        .instr_addr(addr0), .instr_data(mem0[addr0]),
        .A(a0), .B(b0), .C(c0), .fma_result(res0), .fma_flags(flg0),
        .acc_out(acc0), .disp_out(disp0), .flags_out(fo0),
        .exc_sticky(exc0), .busy(busy0), .done(done0));

    fma_sequencer #(.ADDR_W(4), .LAST_ADDR(1), .HOLD_CYCLES(0)) u1 (
        .clk_in(clk_in), .rst(rst), .start(start1),
        .instr_addr(addr1), .instr_data(mem1[addr1]),
        .A(a1), .B(b1), .C(c1), .fma_result(res1), .fma_flags(flg1),
        .acc_out(acc1), .disp_out(disp1), .flags_out(fo1),
        .exc_sticky(exc1), .busy(busy1), .done(done1));

    fma_sequencer #(.ADDR_W(4), .LAST_ADDR(3), .HOLD_CYCLES(3)) u2 (
        .clk_in(clk_in), .rst(rst), .start(start2),
        .instr_addr(addr2), .instr_data(mem2[addr2]),
        .A(a2), .B(b2), .C(c2), .fma_result(res2), .fma_flags(flg2),
        .acc_out(acc2), .disp_out(disp2), .flags_out(fo2),
        .exc_sticky(exc2), .busy(busy2), .done(done2));

    fma_sequencer #(.ADDR_W(4), .LAST_ADDR(15), .HOLD_CYCLES(0)) u3 (
        .clk_in(clk_in), .rst(rst), .start(start3),
        .instr_addr(addr3), .instr_data(mem3[addr3]),
        .A(a3), .B(b3), .C(c3), .fma_result(res3), .fma_flags(flg3),
        .acc_out(acc3), .disp_out(disp3), .flags_out(fo3),
        .exc_sticky(exc3), .busy(busy3), .done(done3));

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic done_of(input int idx);
        case (idx)
            0: return done0;
            1: return done1;
            2: return done2;
            default: return done3;
        endcase
    endfunction

    // Pulse start across one rising edge; returns #1 after that edge.
    task automatic go(input int idx);
        @(negedge clk_in);
        case (idx)
            0: start0 = 1'b1;
            1: start1 = 1'b1;
            2: start2 = 1'b1;
            default: start3 = 1'b1;
        endcase
        @(posedge clk_in);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_done(input int idx, input int budget, output int n);
        n = budget + 1;
        for (int e = 1; e <= budget; e++) begin
            @(posedge clk_in);
            #1;
            if (done_of(idx)) begin
                n = e;
                break;
            end
        end
    endtask

    task automatic model_step(input logic [49:0] w);
        logic [15:0] c;
        logic [15:0] r;
        logic [6:0]  f;
        c = w[48] ? w[15:0] : m_acc;
        r = fstub(w[47:32], w[31:16], c);
        f = fflags(w[47:32], w[31:16], c);
        if (w[49]) m_acc = r;
        else       m_disp = r;
        m_flags = f;
        m_exc   = m_exc | (|f[5:0]);
    endtask

    task automatic run3(input logic use_tbl);
        for (int j = 0; j < 16; j++) mem3[j] = prog[j];
        go(3);
        chk("u3 sticky cleared by start", {31'b0, exc3}, 32'd0);
        chk("u3 busy after start", {31'b0, busy3}, 32'd1);
        m_exc = 1'b0;
        for (int j = 0; j < 16; j++) begin
            @(posedge clk_in);
            @(posedge clk_in);
            #1;
            model_step(prog[j]);
            chk($sformatf("u3 acc i%0d", j), {16'b0, acc3}, {16'b0, m_acc});
            chk($sformatf("u3 disp i%0d", j), {16'b0, disp3}, {16'b0, m_disp});
            chk($sformatf("u3 flags i%0d", j), {25'b0, fo3}, {25'b0, m_flags});
            chk($sformatf("u3 sticky i%0d", j), {31'b0, exc3}, {31'b0, m_exc});
            if (use_tbl)
                chk($sformatf("u3 tbl sticky i%0d", j), {31'b0, exc3},
                    {31'b0, tbl[j].sticky});
        end
        chk("u3 done after 32", {31'b0, done3}, 32'd1);
        chk("u3 addr at done", {28'b0, addr3}, 32'd15);
    endtask

    initial begin
        int n;
        tests = 0;
        fails = 0;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
        for (int j = 0; j < 16; j++) begin
            mem0[j] = '0;
            mem1[j] = '0;
            mem2[j] = '0;
            mem3[j] = '0;
        end
        for (int j = 0; j < 16; j++) begin
            logic [15:0] jj;
            jj = 16'(j);
            tbl[j].word   = {jj[0], jj[1:0] != 2'd0, 16'h3F80 + jj, 16'h4000,
                             16'h0100 * jj};
            tbl[j].sticky = (j >= 3);
        end
        tbl[3].word[47:32] = 16'h7F80;
        m_acc   = '0;
        m_disp  = '0;
        m_flags = '0;
        m_exc   = 1'b0;

        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("reset addr", {28'b0, addr3}, 32'd0);
        chk("reset A/B/C", {a3, b3 | c3}, 32'd0);
        chk("reset acc/disp", {acc3, disp3}, 32'd0);
        chk("reset flags/exc", {24'b0, fo3, exc3}, 32'd0);
        chk("reset busy/done", {30'b0, busy3, done3}, 32'd0);
        #20 rst = 1'b1;

        mem0[0] = {1'b1, 1'b1, 16'h3F80, 16'h4000, 16'h3F80};
        go(0);
        wait_done(0, 10, n);
        chk("u0 done latency", n, 32'd2);
        chk("u0 acc", {16'b0, acc0}, 32'h4040);
        chk("u0 disp", {16'b0, disp0}, 32'h0);

        mem1[0] = {1'b1, 1'b1, 16'h3F80, 16'h4000, 16'h3F80};
        mem1[1] = {1'b0, 1'b0, 16'h3F80, 16'h3F80, 16'h0000};
        go(1);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk_in);
            #1;
            if (e == 3) chk("u1 C feedback", {16'b0, c1}, 32'h4040);
        end
        chk("u1 done", {31'b0, done1}, 32'd1);
        chk("u1 disp", {16'b0, disp1}, 32'h4080);
        chk("u1 acc", {16'b0, acc1}, 32'h4040);

        mem2[0] = {1'b1, 1'b1, 16'h3F80, 16'h4000, 16'h3F80};
        mem2[1] = {1'b0, 1'b0, 16'h3F80, 16'h3F80, 16'h0000};
        mem2[2] = {1'b1, 1'b0, 16'h1234, 16'h0101, 16'h0000};
        mem2[3] = {1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0042};
        go(2);
        for (int e = 1; e <= 21; e++) begin
            @(posedge clk_in);
            #1;
            if (e == 7) start2 = 1'b1;
            if (e == 8) start2 = 1'b0;
            if (e < 20) begin
                chk($sformatf("u2 addr e%0d", e), {28'b0, addr2}, e / 5);
                chk($sformatf("u2 busy e%0d", e), {31'b0, busy2}, 32'd1);
            end else begin
                chk($sformatf("u2 done e%0d", e), {30'b0, busy2, done2}, 32'd1);
                chk($sformatf("u2 addr e%0d", e), {28'b0, addr2}, 32'd3);
            end
        end
        chk("u2 disp", {16'b0, disp2}, 32'h0042);

        go(2);
        @(posedge clk_in);
        #2 rst = 1'b0;
        #1;
        chk("midrun rst busy/done", {30'b0, busy2, done2}, 32'd0);
        chk("midrun rst acc/disp", {acc2, disp2}, 32'd0);
        chk("midrun rst A/C", {a2, c2}, 32'd0);
        chk("midrun rst addr/flags", {21'b0, addr2, fo2, exc2}, 32'd0);
        m_acc   = '0;
        m_disp  = '0;
        m_flags = '0;
        @(negedge clk_in);
        rst = 1'b1;
        go(2);
        wait_done(2, 40, n);
        chk("u2 restart latency", n, 32'd20);
        chk("u2 restart addr", {28'b0, addr2}, 32'd3);

        for (int j = 0; j < 16; j++) prog[j] = tbl[j].word;
        run3(1'b1);
        chk("u3 pos_inf flag seen", {31'b0, m_exc}, 32'd1);
        for (int e = 0; e < 3; e++) begin
            @(posedge clk_in);
            #1;
            chk("u3 no wrap", {27'b0, addr3, done3}, {27'b0, 4'd15, 1'b1});
        end

        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 16; j++) begin
                logic [15:0] a;
                a = ($urandom_range(0, 7) == 0) ? 16'h7F80 : 16'($urandom);
                prog[j] = {1'($urandom), 1'($urandom), a, 16'($urandom),
                           16'($urandom)};
            end
            run3(1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
